// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the VIC/CPU RAM arbiter: state encoding, requester
// indices and a width helper for the starvation counter.
package ram_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    localparam int REQ_VIC = 0;
    localparam int REQ_CPU = 1;
    localparam int NUM_REQ = 2;

    // Bits needed to hold values 0..limit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester, grant/response and RAM-side signals of the arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  vic_req;
    logic [ADDR_WIDTH-1:0] vic_a;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_a;
    logic [DATA_WIDTH-1:0] cpu_di;
    logic                  vic_gnt;
    logic                  cpu_gnt;
    logic                  vic_rvalid;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  init_done;
    logic                  ram_enable;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [DATA_WIDTH-1:0] ram_di;
    logic [DATA_WIDTH-1:0] ram_do;

    modport slave (
        input  vic_req, vic_a, cpu_req, cpu_we, cpu_a, cpu_di, ram_do,
        output vic_gnt, cpu_gnt, vic_rvalid, cpu_rvalid, rdata, init_done,
        output ram_enable, ram_we, ram_a, ram_di
    );

    modport master (
        output vic_req, vic_a, cpu_req, cpu_we, cpu_a, cpu_di,
        input  vic_gnt, cpu_gnt, vic_rvalid, cpu_rvalid, rdata, init_done
    );

    modport ram (
        input  ram_enable, ram_we, ram_a, ram_di,
        output ram_do
    );
endinterface

// File: rtl/ram_arb_prio.sv
// Two-requester priority decision: VIC wins contested cycles unless the CPU
// has waited long enough to trip the starvation threshold.
module ram_arb_prio (
    input  logic i_vic_req,
    input  logic i_cpu_req,
    input  logic i_starve_hit,
    output logic o_vic_gnt,
    output logic o_cpu_gnt
);
    logic w_cpu_wins;

    assign w_cpu_wins = i_cpu_req && (!i_vic_req || i_starve_hit);
    assign o_cpu_gnt  = w_cpu_wins;
    assign o_vic_gnt  = i_vic_req && !w_cpu_wins;
endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between a read-only VIC and a read/write CPU,
// with an optional clear-sweep of the whole RAM after reset.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    INIT_EN      = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE   = '0,
    parameter int                    STARVE_LIMIT = 7
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    localparam int         SW          = cnt_width(STARVE_LIMIT);
    localparam arb_state_t RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic       RESET_DONE  = (INIT_EN == 0);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_sweep;
    logic [ADDR_WIDTH-1:0] w_sweep_next;
    logic [SW-1:0]         r_starve;
    logic                  r_init_done;
    logic [NUM_REQ-1:0]    r_rvalid;
    logic [NUM_REQ-1:0]    w_rd_gnt;
    logic                  w_run;
    logic                  w_starve_hit;
    logic                  w_vic_gnt;
    logic                  w_cpu_gnt;

    assign w_run        = (r_state == ST_RUN);
    assign w_starve_hit = (r_starve == SW'(STARVE_LIMIT));

    ram_arb_prio u_prio (
        .i_vic_req    (w_run && bus.vic_req),
        .i_cpu_req    (w_run && bus.cpu_req),
        .i_starve_hit (w_starve_hit),
        .o_vic_gnt    (w_vic_gnt),
        .o_cpu_gnt    (w_cpu_gnt)
    );

    always_comb begin
        w_state_next = r_state;
        w_sweep_next = r_sweep;
        if (r_state == ST_INIT) begin
            w_sweep_next = r_sweep + ADDR_WIDTH'(1);
            if (&r_sweep) begin
                w_state_next = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_sweep     <= '0;
            r_init_done <= RESET_DONE;
        end else begin
            r_state     <= w_state_next;
            r_sweep     <= w_sweep_next;
            r_init_done <= (w_state_next == ST_RUN);
        end
    end

    // A CPU that is granted, or stops asking, starts its wait count afresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_run && bus.cpu_req && !w_cpu_gnt) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= '0;
        end
    end

    assign w_rd_gnt[REQ_VIC] = w_vic_gnt;
    assign w_rd_gnt[REQ_CPU] = w_cpu_gnt && !bus.cpu_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_rd_gnt;
        end
    end

    always_comb begin
        bus.ram_enable = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_a      = '0;
        bus.ram_di     = '0;
        if (r_state == ST_INIT) begin
            bus.ram_enable = 1'b1;
            bus.ram_we     = 1'b1;
            bus.ram_a      = r_sweep;
            bus.ram_di     = FILL_VALUE;
        end else if (w_cpu_gnt) begin
            bus.ram_enable = 1'b1;
            bus.ram_we     = bus.cpu_we;
            bus.ram_a      = bus.cpu_a;
            bus.ram_di     = bus.cpu_di;
        end else if (w_vic_gnt) begin
            bus.ram_enable = 1'b1;
            bus.ram_a      = bus.vic_a;
        end
    end

    assign bus.vic_gnt    = w_vic_gnt;
    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.vic_rvalid = r_rvalid[REQ_VIC];
    assign bus.cpu_rvalid = r_rvalid[REQ_CPU];
    assign bus.init_done  = r_init_done;
    assign bus.rdata      = bus.ram_do;
endmodule
